// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared types, limits and helpers for the reset sequencer
package reset_seq_pkg;

   localparam int MAX_STAGES = 8;
   localparam int RETRY_W    = 4;

   typedef enum logic [2:0] {
      S_HOLD,
      S_DELAY,
      S_WAIT,
      S_RUN,
      S_FAULT
   } seq_state_e;

   // Elaboration-time ceil(log2); returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - condition inputs and per-domain reset outputs of the sequencer
interface reset_sequencer_if #(
   parameter int NUM_STAGES = 4
);
   import reset_seq_pkg::*;

   logic                          pll_lock_i;
   logic                          init_done_i;
   logic                          soft_rst_i;
   logic [NUM_STAGES-1:0]         stage_ready_i;
   logic [NUM_STAGES-1:0]         reset_n_out_o;
   logic                          seq_done_o;
   logic                          fault_o;
   logic [clog2(MAX_STAGES)-1:0]  fault_stage_o;
   logic [RETRY_W-1:0]            retry_cnt_o;

   modport master (
      output pll_lock_i, init_done_i, soft_rst_i, stage_ready_i,
      input  reset_n_out_o, seq_done_o, fault_o, fault_stage_o, retry_cnt_o
   );

   modport slave (
      input  pll_lock_i, init_done_i, soft_rst_i, stage_ready_i,
      output reset_n_out_o, seq_done_o, fault_o, fault_stage_o, retry_cnt_o
   );

endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// rtl/reset_sequencer_sync_2ff.sv - two-flop synchronizer bank for asynchronous inputs
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with per-stage delay, ready timeout and retries
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int DELAY_CYCLES   = 256,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int RETRY_MAX      = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   reset_sequencer_if.slave seq_if
);

   localparam int CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = clog2(CNT_MAX) + 1;
   localparam int IDX_W   = (NUM_STAGES > 1) ? clog2(NUM_STAGES) : 1;
   localparam int FS_W    = clog2(MAX_STAGES);

   logic [NUM_STAGES+1:0] sync_out;
   logic                  lock_s;
   logic                  init_s;
   logic [NUM_STAGES-1:0] ready_s;

   seq_state_e            state_q,  state_d;
   logic [IDX_W-1:0]      k_q,      k_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [NUM_STAGES-1:0] rstn_q,   rstn_d;
   logic                  done_q,   done_d;
   logic                  fault_q,  fault_d;
   logic [FS_W-1:0]       fstage_q, fstage_d;
   logic [RETRY_W-1:0]    retry_q,  retry_d;

   sync_2ff #(.WIDTH(NUM_STAGES + 2)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   ({seq_if.stage_ready_i, seq_if.init_done_i, seq_if.pll_lock_i}),
      .q_o   (sync_out)
   );

   assign lock_s  = sync_out[0];
   assign init_s  = sync_out[1];
   assign ready_s = sync_out[NUM_STAGES+1:2];

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      rstn_d   = rstn_q;
      fault_d  = fault_q;
      fstage_d = fstage_q;
      retry_d  = retry_q;

      if (seq_if.soft_rst_i) begin
         state_d = S_HOLD;
         k_d     = '0;
         cnt_d   = '0;
         rstn_d  = '0;
         fault_d = 1'b0;
         retry_d = '0;
      end else if (!lock_s && state_q != S_HOLD) begin
         // Lock loss keeps the fault record so software can still inspect it.
         state_d = S_HOLD;
         k_d     = '0;
         cnt_d   = '0;
         rstn_d  = '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               rstn_d = '0;
               if (lock_s && init_s) begin
                  state_d = S_DELAY;
                  k_d     = '0;
                  cnt_d   = '0;
               end
            end
            S_DELAY: begin
               if (cnt_q == CNT_W'(DELAY_CYCLES - 1)) begin
                  rstn_d[k_q] = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_WAIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_WAIT: begin
               // Ready is tested before the timeout so a late ready still counts.
               if (ready_s[k_q]) begin
                  retry_d = '0;
                  cnt_d   = '0;
                  if (k_q == IDX_W'(NUM_STAGES - 1)) begin
                     state_d = S_RUN;
                     rstn_d  = '1;
                  end else begin
                     k_d     = k_q + 1'b1;
                     state_d = S_DELAY;
                  end
               end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_W'(RETRY_MAX)) begin
                     retry_d     = retry_q + 1'b1;
                     rstn_d[k_q] = 1'b0;
                     state_d     = S_DELAY;
                  end else begin
                     state_d  = S_FAULT;
                     fault_d  = 1'b1;
                     fstage_d = FS_W'(k_q);
                     for (int i = 0; i < NUM_STAGES; i++) begin
                        rstn_d[i] = (i < int'(k_q));
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               rstn_d = '1;
            end
            S_FAULT: begin
               rstn_d = rstn_q;
            end
            default: begin
               state_d = S_HOLD;
               rstn_d  = '0;
               cnt_d   = '0;
               k_d     = '0;
            end
         endcase
      end

      done_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_HOLD;
         k_q      <= '0;
         cnt_q    <= '0;
         rstn_q   <= '0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         fstage_q <= '0;
         retry_q  <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         rstn_q   <= rstn_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
         fstage_q <= fstage_d;
         retry_q  <= retry_d;
      end
   end

   assign seq_if.reset_n_out_o = rstn_q;
   assign seq_if.seq_done_o    = done_q;
   assign seq_if.fault_o       = fault_q;
   assign seq_if.fault_stage_o = fstage_q;
   assign seq_if.retry_cnt_o   = retry_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;
   int   rel_nom [4];
   int   r;

   reset_sequencer_if #(.NUM_STAGES(4)) seq_if ();

   reset_sequencer #(
      .NUM_STAGES     (4),
      .DELAY_CYCLES   (8),
      .TIMEOUT_CYCLES (32),
      .RETRY_MAX      (3)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .seq_if (seq_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Releases RST right after an edge; the next edge is cycle 1.
   task automatic restart(input logic [3:0] ready);
      rst = 1'b1;
      seq_if.soft_rst_i    = 1'b0;
      seq_if.pll_lock_i    = 1'b1;
      seq_if.init_done_i   = 1'b1;
      seq_if.stage_ready_i = ready;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic chk_rstn(input string tag, input logic [3:0] exp);
      chk(tag, 32'(seq_if.reset_n_out_o), 32'(exp));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rel_nom = '{11, 27, 43, 59};
      rst = 1'b1;
      seq_if.pll_lock_i    = 1'b1;
      seq_if.init_done_i   = 1'b1;
      seq_if.soft_rst_i    = 1'b0;
      seq_if.stage_ready_i = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_rstn("reset_rstn", 4'h0);
      chk("reset_done",   32'(seq_if.seq_done_o),    32'd0);
      chk("reset_fault",  32'(seq_if.fault_o),       32'd0);
      chk("reset_fstage", 32'(seq_if.fault_stage_o), 32'd0);
      chk("reset_retry",  32'(seq_if.retry_cnt_o),   32'd0);

      // Nominal: each ready raised 5 cycles after its release.
      restart(4'h0);
      for (int s = 0; s < 4; s++) begin
         r = rel_nom[s];
         wait_until(r - 1);
         chk_rstn("nom_pre", 4'((1 << s) - 1));
         wait_until(r);
         chk_rstn("nom_rel", 4'((1 << (s + 1)) - 1));
         wait_until(r + 5);
         seq_if.stage_ready_i[s] = 1'b1;
      end
      wait_until(66);
      chk("nom_done_pre", 32'(seq_if.seq_done_o), 32'd0);
      wait_until(67);
      chk("nom_done", 32'(seq_if.seq_done_o), 32'd1);
      chk_rstn("nom_run", 4'hf);

      // Lock loss in S_RUN, then full restart with readies already high.
      wait_until(70);
      seq_if.pll_lock_i = 1'b0;
      wait_until(72);
      chk_rstn("lol_pre", 4'hf);
      chk("lol_done_pre", 32'(seq_if.seq_done_o), 32'd1);
      wait_until(73);
      chk_rstn("lol_rstn", 4'h0);
      chk("lol_done", 32'(seq_if.seq_done_o), 32'd0);
      wait_until(80);
      seq_if.pll_lock_i = 1'b1;
      wait_until(90);
      chk_rstn("relock_pre", 4'h0);
      wait_until(91);
      chk_rstn("relock_s0", 4'h1);
      wait_until(100);
      chk_rstn("relock_s1", 4'h3);
      wait_until(118);
      chk_rstn("relock_s3", 4'hf);
      chk("relock_done_pre", 32'(seq_if.seq_done_o), 32'd0);
      wait_until(119);
      chk("relock_done", 32'(seq_if.seq_done_o), 32'd1);

      // Retry: stage 1 never ready.
      restart(4'h0);
      wait_until(11);
      seq_if.stage_ready_i[0] = 1'b1;
      wait_until(21);
      chk_rstn("rty_pre_s1", 4'h1);
      wait_until(22);
      chk_rstn("rty_rel_s1", 4'h3);
      wait_until(53);
      chk_rstn("rty_before_to", 4'h3);
      chk("rty_cnt0", 32'(seq_if.retry_cnt_o), 32'd0);
      wait_until(54);
      chk_rstn("rty_to1", 4'h1);
      chk("rty_cnt1", 32'(seq_if.retry_cnt_o), 32'd1);
      wait_until(61);
      chk_rstn("rty_hold", 4'h1);
      wait_until(62);
      chk_rstn("rty_rerel", 4'h3);
      wait_until(94);
      chk_rstn("rty_to2", 4'h1);
      chk("rty_cnt2", 32'(seq_if.retry_cnt_o), 32'd2);
      wait_until(134);
      chk("rty_cnt3", 32'(seq_if.retry_cnt_o), 32'd3);
      wait_until(142);
      chk_rstn("rty_rerel3", 4'h3);
      wait_until(173);
      chk("rty_fault_pre", 32'(seq_if.fault_o), 32'd0);
      wait_until(174);
      chk("rty_fault", 32'(seq_if.fault_o), 32'd1);
      chk("rty_fstage", 32'(seq_if.fault_stage_o), 32'd1);
      chk_rstn("rty_fault_rstn", 4'h1);
      chk("rty_fault_done", 32'(seq_if.seq_done_o), 32'd0);

      // Fault recovery through SOFT_RST.
      wait_until(176);
      chk("fault_sticky", 32'(seq_if.fault_o), 32'd1);
      seq_if.stage_ready_i = 4'hf;
      seq_if.soft_rst_i    = 1'b1;
      wait_until(177);
      seq_if.soft_rst_i = 1'b0;
      chk("rec_fault_clr", 32'(seq_if.fault_o), 32'd0);
      chk("rec_retry_clr", 32'(seq_if.retry_cnt_o), 32'd0);
      chk_rstn("rec_rstn", 4'h0);
      wait_until(185);
      chk_rstn("rec_pre_s0", 4'h0);
      wait_until(186);
      chk_rstn("rec_s0", 4'h1);
      wait_until(213);
      chk_rstn("rec_s3", 4'hf);
      wait_until(214);
      chk("rec_done", 32'(seq_if.seq_done_o), 32'd1);
      chk("rec_fault", 32'(seq_if.fault_o), 32'd0);

      // Ready and timeout coincide on stage 2.
      restart(4'h0);
      wait_until(11);
      seq_if.stage_ready_i[0] = 1'b1;
      wait_until(22);
      chk_rstn("sim_s1", 4'h3);
      seq_if.stage_ready_i[1] = 1'b1;
      wait_until(33);
      chk_rstn("sim_s2", 4'h7);
      wait_until(62);
      seq_if.stage_ready_i[2] = 1'b1;
      wait_until(64);
      chk_rstn("sim_pre_to", 4'h7);
      wait_until(65);
      chk_rstn("sim_to_rstn", 4'h7);
      chk("sim_to_retry", 32'(seq_if.retry_cnt_o), 32'd0);
      wait_until(72);
      chk_rstn("sim_pre_s3", 4'h7);
      wait_until(73);
      chk_rstn("sim_s3", 4'hf);

      // SOFT_RST on the stage-3 timeout edge.
      wait_until(104);
      chk_rstn("srto_pre", 4'hf);
      seq_if.soft_rst_i = 1'b1;
      wait_until(105);
      seq_if.soft_rst_i = 1'b0;
      chk_rstn("srto_rstn", 4'h0);
      chk("srto_retry", 32'(seq_if.retry_cnt_o), 32'd0);
      chk("srto_fault", 32'(seq_if.fault_o), 32'd0);
      seq_if.stage_ready_i[2] = 1'b0;

      // RST asserted while waiting on stage 2.
      wait_until(114);
      chk_rstn("mid_s0", 4'h1);
      wait_until(132);
      chk_rstn("mid_s2", 4'h7);
      wait_until(140);
      chk_rstn("mid_wait", 4'h7);
      rst = 1'b1;
      #2;
      chk_rstn("mid_async_rstn", 4'h0);
      chk("mid_async_done",  32'(seq_if.seq_done_o),  32'd0);
      chk("mid_async_fault", 32'(seq_if.fault_o),     32'd0);
      chk("mid_async_retry", 32'(seq_if.retry_cnt_o), 32'd0);
      restart(4'hf);
      wait_until(10);
      chk_rstn("mid_re_pre", 4'h0);
      wait_until(11);
      chk_rstn("mid_re_s0", 4'h1);
      wait_until(20);
      chk_rstn("mid_re_s1", 4'h3);
      wait_until(38);
      chk_rstn("mid_re_s3", 4'hf);
      wait_until(39);
      chk("mid_re_done", 32'(seq_if.seq_done_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
